// File: rtl/flame_vga_timing.sv
// Raster timing generator for a VGA-style display.
// Produces pixel/line position counters, a frame counter, sync pulses,
// display enable and start-of-line/start-of-frame ticks. Every output is
// registered from the same next-state position, so the sync and enable
// signals always match the x/y value shown in the same cycle.
module flame_vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [7:0] frame,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode boundaries are 11 bits wide so an end value of 1024 still compares correctly.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_B = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_B = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_E = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic [7:0] frame_q, frame_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       de_q, de_d;
    logic       ls_q;
    logic       fs_q;
    logic       x_wrap;
    logic       y_wrap;

    // Next raster position and frame count for an advancing edge.
    always_comb begin
        x_wrap  = (x_q == H_LAST);
        y_wrap  = (y_q == V_LAST);
        x_d     = x_wrap ? 10'd0 : x_q + 10'd1;
        y_d     = y_q;
        frame_d = frame_q;
        if (x_wrap) begin
            y_d = y_wrap ? 10'd0 : y_q + 10'd1;
            if (y_wrap) begin
                frame_d = frame_q + 8'd1;
            end
        end
    end

    // Decode sync/enable from the next position so they register alongside it.
    always_comb begin
        de_d = ({1'b0, x_d} < H_ACT_E) && ({1'b0, y_d} < V_ACT_E);
        hs_d = (({1'b0, x_d} >= H_SYNC_B) && ({1'b0, x_d} < H_SYNC_E)) ? SYNC_ACT : ~SYNC_ACT;
        vs_d = (({1'b0, y_d} >= V_SYNC_B) && ({1'b0, y_d} < V_SYNC_E)) ? SYNC_ACT : ~SYNC_ACT;
    end

    // Counter and output registers; hold everything but the ticks while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            frame_q <= 8'd0;
            de_q    <= 1'b1;
            hs_q    <= ~SYNC_ACT;
            vs_q    <= ~SYNC_ACT;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (ena) begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= x_wrap;
            fs_q    <= x_wrap && y_wrap;
        end else begin
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign frame       = frame_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_flame_vga_timing.sv
// Bench for flame_vga_timing: default-timing instances of both sync polarities
// plus a reduced-timing instance for whole-frame and frame-counter wrap behaviour.
module tb_flame_vga_timing;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] frame;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } exp_t;

    typedef struct packed {
        logic ena;
        exp_t e;
    } vec_t;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
        bit pol;
    } tcfg_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, ena0, rst2_n, ena2;
    logic hs0, vs0, de0, ls0, fs0;
    logic hs1, vs1, de1, ls1, fs1;
    logic hs2, vs2, de2, ls2, fs2;
    logic [9:0] x0, y0, x1, y1, x2, y2;
    logic [7:0] fr0, fr1, fr2;

    flame_vga_timing #(.SYNC_POL(0)) dut0 (
        .clk(clk), .rst_n(rst0_n), .ena(ena0), .hsync(hs0), .vsync(vs0), .de(de0),
        .x(x0), .y(y0), .frame(fr0), .line_start(ls0), .frame_start(fs0));

    flame_vga_timing #(.SYNC_POL(1)) dut1 (
        .clk(clk), .rst_n(rst0_n), .ena(ena0), .hsync(hs1), .vsync(vs1), .de(de1),
        .x(x1), .y(y1), .frame(fr1), .line_start(ls1), .frame_start(fs1));

    flame_vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .ena(ena2), .hsync(hs2), .vsync(vs2), .de(de2),
        .x(x2), .y(y2), .frame(fr2), .line_start(ls2), .frame_start(fs2));

    function automatic exp_t pack(logic [9:0] xx, logic [9:0] yy, logic [7:0] ff,
                                  logic d, logic h, logic v, logic l, logic f);
        exp_t r;
        r.x = xx; r.y = yy; r.frame = ff;
        r.de = d; r.hs = h; r.vs = v; r.ls = l; r.fs = f;
        return r;
    endfunction

    function automatic exp_t g0();
        return pack(x0, y0, fr0, de0, hs0, vs0, ls0, fs0);
    endfunction
    function automatic exp_t g1();
        return pack(x1, y1, fr1, de1, hs1, vs1, ls1, fs1);
    endfunction
    function automatic exp_t g2();
        return pack(x2, y2, fr2, de2, hs2, vs2, ls2, fs2);
    endfunction

    // Reference: position is a linear pixel index within the frame.
    function automatic exp_t mexp(tcfg_t c, int cnt, int frm, bit adv);
        exp_t r;
        int ht;
        int xx;
        int yy;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        xx = cnt % ht;
        yy = cnt / ht;
        r.x = 10'(xx);
        r.y = 10'(yy);
        r.frame = 8'(frm);
        r.de = (xx < c.ha) && (yy < c.va);
        r.hs = ((xx >= c.ha + c.hfp) && (xx < c.ha + c.hfp + c.hsw)) ? c.pol : !c.pol;
        r.vs = ((yy >= c.va + c.vfp) && (yy < c.va + c.vfp + c.vsw)) ? c.pol : !c.pol;
        r.ls = adv && (xx == 0);
        r.fs = adv && (cnt == 0);
        return r;
    endfunction

    task automatic mstep(input tcfg_t c, input bit e, inout int cnt, inout int frm, inout bit adv);
        int tot;
        tot = (c.ha + c.hfp + c.hsw + c.hbp) * (c.va + c.vfp + c.vsw + c.vbp);
        if (e) begin
            cnt = (cnt + 1) % tot;
            if (cnt == 0) frm = (frm + 1) % 256;
            adv = 1'b1;
        end else begin
            adv = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input exp_t g, input exp_t e);
        checks++;
        if (g !== e) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got x=%0d y=%0d frame=%0d de=%b hs=%b vs=%b ls=%b fs=%b, want x=%0d y=%0d frame=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
                         nm, g.x, g.y, g.frame, g.de, g.hs, g.vs, g.ls, g.fs,
                         e.x, e.y, e.frame, e.de, e.hs, e.vs, e.ls, e.fs);
        end
    endtask

    task automatic chk_int(input string nm, input int g, input int e);
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, g, e);
        end
    endtask

    function automatic vec_t mkv(bit en, int xx, int yy, bit d, bit h, bit l);
        vec_t r;
        r.ena = en;
        r.e = pack(10'(xx), 10'(yy), 8'd0, d, h, 1'b1, l, 1'b0);
        return r;
    endfunction

    tcfg_t C0, C1, C2;
    int    cnt0, frm0, cnt2, frm2;
    bit    adv0, adv2;
    vec_t  tbl[20];

    initial begin
        int hold, lsn, hsn, guard, fsn, vsn;
        C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        C1 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1};
        C2 = '{8, 2, 3, 3, 6, 1, 2, 1, 1'b0};

        // Small-instance vectors from reset: {ena, x, y, de, hsync, line_start}
        tbl[0]  = mkv(1, 1, 0, 1, 1, 0);
        tbl[1]  = mkv(1, 2, 0, 1, 1, 0);
        tbl[2]  = mkv(1, 3, 0, 1, 1, 0);
        tbl[3]  = mkv(0, 3, 0, 1, 1, 0);
        tbl[4]  = mkv(1, 4, 0, 1, 1, 0);
        tbl[5]  = mkv(1, 5, 0, 1, 1, 0);
        tbl[6]  = mkv(1, 6, 0, 1, 1, 0);
        tbl[7]  = mkv(1, 7, 0, 1, 1, 0);
        tbl[8]  = mkv(1, 8, 0, 0, 1, 0);
        tbl[9]  = mkv(1, 9, 0, 0, 1, 0);
        tbl[10] = mkv(0, 9, 0, 0, 1, 0);
        tbl[11] = mkv(1, 10, 0, 0, 0, 0);
        tbl[12] = mkv(1, 11, 0, 0, 0, 0);
        tbl[13] = mkv(1, 12, 0, 0, 0, 0);
        tbl[14] = mkv(1, 13, 0, 0, 1, 0);
        tbl[15] = mkv(1, 14, 0, 0, 1, 0);
        tbl[16] = mkv(1, 15, 0, 0, 1, 0);
        tbl[17] = mkv(1, 0, 1, 1, 1, 1);
        tbl[18] = mkv(0, 0, 1, 1, 1, 0);
        tbl[19] = mkv(1, 1, 1, 1, 1, 0);

        rst0_n = 1'b0; ena0 = 1'b0; rst2_n = 1'b0; ena2 = 1'b0;
        cnt0 = 0; frm0 = 0; adv0 = 1'b0;
        cnt2 = 0; frm2 = 0; adv2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset0", g0(), pack(10'd0, 10'd0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
        chk("reset1", g1(), pack(10'd0, 10'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        chk("reset2", g2(), mexp(C2, 0, 0, 1'b0));

        // Default timing: first line, a 37-clock hold at x=655, into line 1 up to x=700.
        rst0_n = 1'b1;
        hold = 0; lsn = 0; hsn = 0; guard = 0;
        while (cnt0 != 1500 && guard < 4000) begin
            if (cnt0 == 655 && hold < 37) begin
                ena0 = 1'b0;
                hold++;
            end else begin
                ena0 = 1'b1;
            end
            @(posedge clk);
            mstep(C0, ena0, cnt0, frm0, adv0);
            #1;
            chk("line0", g0(), mexp(C0, cnt0, frm0, adv0));
            chk("line1", g1(), mexp(C1, cnt0, frm0, adv0));
            if (ena0 && cnt0 == 656)
                chk("hold_release", pack(x0, y0, 8'd0, 1'b0, hs0, 1'b0, ls0, 1'b0),
                    pack(10'd656, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            if (ls0) lsn++;
            if (!hs0 && y0 == 10'd0) hsn++;
            guard++;
        end
        chk_int("reach_x700", cnt0, 1500);
        chk_int("ls_count", lsn, 1);
        chk_int("hs_low_clocks", hsn, 96);

        // Asynchronous reset between clock edges.
        #2 rst0_n = 1'b0;
        cnt0 = 0; frm0 = 0; adv0 = 1'b0;
        #1;
        chk("async_rst0", g0(), mexp(C0, 0, 0, 1'b0));
        chk("async_rst1", g1(), mexp(C1, 0, 0, 1'b0));
        ena0 = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_held0", g0(), mexp(C0, 0, 0, 1'b0));
        ena0 = 1'b0;
        rst0_n = 1'b1;

        // Small timing: table vectors.
        rst2_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ena2 = tbl[i].ena;
            @(posedge clk);
            mstep(C2, ena2, cnt2, frm2, adv2);
            #1;
            chk($sformatf("vec%0d", i), g2(), tbl[i].e);
        end

        // Random enable against the reference, with one mid-frame async reset.
        for (int i = 0; i < 2000; i++) begin
            ena2 = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            mstep(C2, ena2, cnt2, frm2, adv2);
            #1;
            chk("rand", g2(), mexp(C2, cnt2, frm2, adv2));
            if (i == 1000) begin
                #2 rst2_n = 1'b0;
                cnt2 = 0; frm2 = 0; adv2 = 1'b0;
                #1;
                chk("rand_async_rst", g2(), mexp(C2, 0, 0, 1'b0));
                rst2_n = 1'b1;
            end
        end

        // 256 full frames with ena high: frame sequence and tick count.
        rst2_n = 1'b0;
        cnt2 = 0; frm2 = 0; adv2 = 1'b0;
        #1 rst2_n = 1'b1;
        ena2 = 1'b1;
        fsn = 0; vsn = 0;
        for (int i = 0; i < 256 * 160; i++) begin
            @(posedge clk);
            mstep(C2, ena2, cnt2, frm2, adv2);
            #1;
            chk("frames", g2(), mexp(C2, cnt2, frm2, adv2));
            if (fs2) begin
                fsn++;
                chk_int("frame_seq", int'(fr2), fsn % 256);
            end
            if (fsn == 0 && !vs2) vsn++;
        end
        chk_int("fs_count", fsn, 256);
        chk_int("frame_final", int'(fr2), 0);
        chk_int("vs_low_clocks", vsn, 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
